// File: rtl/mag_cmp_seq_if.sv
// Request/response bundle for mag_cmp_seq.
//   req_vld/req_rdy/req_val/req_rfr : operand request handshake
//   rsp_vld/rsp_rdy/rsp_grt/rsp_lst : compare result handshake
// master = requester side, slave = comparator side.
interface mag_cmp_seq_if #(
   parameter int WIDTH = 32
);
   logic             req_vld;
   logic             req_rdy;
   logic [WIDTH-1:0] req_val;
   logic [WIDTH-1:0] req_rfr;
   logic             rsp_vld;
   logic             rsp_rdy;
   logic             rsp_grt;
   logic             rsp_lst;

   modport master (
      output req_vld, req_val, req_rfr, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_grt, rsp_lst
   );

   modport slave (
      input  req_vld, req_val, req_rfr, rsp_rdy,
      output req_rdy, rsp_vld, rsp_grt, rsp_lst
   );
endinterface

// File: rtl/mag_cmp_seq.sv
// Multi-cycle unsigned magnitude comparator. One CHUNK-wide mag_cmp_base is
// stepped over the captured operands, MSB chunk first; one op in flight.
// Ports:
//   clk, rst_n : clock (rising), asynchronous active-low reset
//   bus        : mag_cmp_seq_if.slave request/response handshakes
//   busy       : high while an operation is in progress (state != IDLE)
// Build option: define MAG_CMP_SEQ_EARLY_EXIT_EN to leave CMP at the first
// differing chunk; otherwise all N chunks are always examined (constant time).

// Single-chunk comparator. IMPLEMENTATION selects relational operators (0)
// or a borrow-based subtractor (other values); results are identical.
module mag_cmp_base #(
   parameter int WIDTH          = 8,
   parameter int IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             grt,
   output logic             lst
);
   generate
      if (IMPLEMENTATION == 0) begin : g_rel
         assign grt = (a > b);
         assign lst = (a < b);
      end else begin : g_sub
         logic [WIDTH:0] diff;
         assign diff = {1'b0, a} - {1'b0, b};
         assign lst  = diff[WIDTH];
         assign grt  = ~diff[WIDTH] & (|diff[WIDTH-1:0]);
      end
   endgenerate
endmodule

module mag_cmp_seq #(
   parameter int WIDTH          = 32,
   parameter int CHUNK          = 8,
   parameter int IMPLEMENTATION = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   mag_cmp_seq_if.slave bus,
   output logic         busy
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_cfg
         $fatal(1, "mag_cmp_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;

   state_t                     state_q, state_d;
   logic [N-1:0][CHUNK-1:0]    val_q, rfr_q;
   logic [CW-1:0]              cnt_q;
   logic                       grt_q, lst_q;
   logic                       c_grt, c_lst;
   logic                       fire, dec, fin, fin_grt, fin_lst;

   mag_cmp_base #(.WIDTH(CHUNK), .IMPLEMENTATION(IMPLEMENTATION)) u_cmp (
      .a   (val_q[cnt_q]),
      .b   (rfr_q[cnt_q]),
      .grt (c_grt),
      .lst (c_lst)
   );

`ifndef MAG_CMP_SEQ_EARLY_EXIT_EN
   // Sticky accumulator: the first nonzero chunk result (from the MSB side)
   // decides the outcome; later chunks may not overwrite it.
   logic acc_grt_q, acc_lst_q;
   logic hit_grt, hit_lst;
   assign hit_grt = (acc_grt_q | acc_lst_q) ? acc_grt_q : c_grt;
   assign hit_lst = (acc_grt_q | acc_lst_q) ? acc_lst_q : c_lst;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      fire    = 1'b0;
      dec     = 1'b0;
      fin     = 1'b0;
      fin_grt = 1'b0;
      fin_lst = 1'b0;
      case (state_q)
         IDLE: if (bus.req_vld) begin
            fire    = 1'b1;
            state_d = CMP;
         end
         CMP: begin
`ifdef MAG_CMP_SEQ_EARLY_EXIT_EN
            if (c_grt | c_lst) begin
               fin     = 1'b1;
               fin_grt = c_grt;
               fin_lst = c_lst;
            end else if (cnt_q == '0) begin
               fin = 1'b1;
            end else begin
               dec = 1'b1;
            end
`else
            if (cnt_q == '0) begin
               fin     = 1'b1;
               fin_grt = hit_grt;
               fin_lst = hit_lst;
            end else begin
               dec = 1'b1;
            end
`endif
            if (fin) state_d = RSP;
         end
         RSP: if (bus.rsp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= '0;
         rfr_q <= '0;
         cnt_q <= '0;
         grt_q <= 1'b0;
         lst_q <= 1'b0;
      end else begin
         if (fire) begin
            val_q <= bus.req_val;
            rfr_q <= bus.req_rfr;
            cnt_q <= CW'(N - 1);
         end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
         end
         // Result regs only change when an op completes; they hold across
         // the response stall and after the handshake.
         if (fin) begin
            grt_q <= fin_grt;
            lst_q <= fin_lst;
         end
      end
   end

`ifndef MAG_CMP_SEQ_EARLY_EXIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_grt_q <= 1'b0;
         acc_lst_q <= 1'b0;
      end else if (fire) begin
         acc_grt_q <= 1'b0;
         acc_lst_q <= 1'b0;
      end else if (dec) begin
         acc_grt_q <= hit_grt;
         acc_lst_q <= hit_lst;
      end
   end
`endif

   assign bus.req_rdy = (state_q == IDLE);
   assign bus.rsp_vld = (state_q == RSP);
   assign bus.rsp_grt = grt_q;
   assign bus.rsp_lst = lst_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mag_cmp_seq.sv
module tb_mag_cmp_seq;
   localparam int WIDTH = 32;
   localparam int CHUNK = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   mag_cmp_seq_if #(.WIDTH(WIDTH)) bus ();

   mag_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IMPLEMENTATION(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      logic [31:0] rfr;
      logic        grt;
      logic        lst;
      int          lat_e;   // latency with early exit
      int          lat_c;   // latency in constant-time build
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input int le, input int lc);
`ifdef MAG_CMP_SEQ_EARLY_EXIT_EN
      return le;
`else
      return lc;
`endif
   endfunction

   // Issue one request, return cycles from accept edge to rsp_vld and the
   // result. Returns at Ek+#1 with rsp_vld high (or lat=99 on timeout).
   task automatic run_op(input logic [31:0] v, input logic [31:0] r,
                         output int lat, output logic g, output logic l);
      int w = 0;
      bus.req_val = v;
      bus.req_rfr = r;
      bus.req_vld = 1'b1;
      while (!bus.req_rdy && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 bus.req_vld = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.rsp_vld) break;
      end
      if (!bus.rsp_vld) lat = 99;
      g = bus.rsp_grt;
      l = bus.rsp_lst;
   endtask

   // Result flags must never both be set.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_grt && bus.rsp_lst) begin
         checks++;
         errors++;
         $display("FAIL grt_lst_exclusive actual=11 required=not both");
      end
   end

   initial begin
      int          lat;
      logic        g, l;
      int          acc, rsp, last, cyc, extra;

      vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 4, 4};
      vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 4};
      vecs[2] = '{32'h000000FE, 32'h000000FF, 1'b0, 1'b1, 4, 4};
      vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1, 4};
      vecs[4] = '{32'h00000005, 32'h00000003, 1'b1, 1'b0, 4, 4};
      vecs[5] = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 4, 4};
      vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 4, 4};
      vecs[7] = '{32'h00010000, 32'h0001FFFF, 1'b0, 1'b0, 0, 0};
      // 0x00010000 vs 0x0001FFFF: chunks 3,2 equal, chunk 1 differs -> lst
      vecs[7].lst   = 1'b1;
      vecs[7].lat_e = 3;
      vecs[7].lat_c = 4;

      rst_n       = 1'b0;
      bus.req_vld = 1'b0;
      bus.req_val = '0;
      bus.req_rfr = '0;
      bus.rsp_rdy = 1'b1;
      #12;
      chk("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
      chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("rst_busy",    32'(busy),        32'd0);
      chk("rst_grt",     32'(bus.rsp_grt), 32'd0);
      chk("rst_lst",     32'(bus.rsp_lst), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].val, vecs[i].rfr, lat, g, l);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].lat_e, vecs[i].lat_c)));
         chk($sformatf("vec%0d_grt", i), 32'(g), 32'(vecs[i].grt));
         chk($sformatf("vec%0d_lst", i), 32'(l), 32'(vecs[i].lst));
         @(negedge clk);
      end

      // Backpressure: response stalled while a new request waits
      @(negedge clk);
      bus.rsp_rdy = 1'b0;
      run_op(32'h80000000, 32'h7FFFFFFF, lat, g, l);
      chk("bp_lat", 32'(lat), 32'(exp_lat(1, 4)));
      @(negedge clk);
      bus.req_val = 32'h00000001;
      bus.req_rfr = 32'h00000002;
      bus.req_vld = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_rsp_vld", 32'(bus.rsp_vld), 32'd1);
         chk("bp_grt",     32'(bus.rsp_grt), 32'd1);
         chk("bp_lst",     32'(bus.rsp_lst), 32'd0);
         chk("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
         chk("bp_busy",    32'(busy),        32'd1);
         @(negedge clk);
      end
      bus.rsp_rdy = 1'b1;
      @(posedge clk);          // handshake edge
      #1;
      chk("bp_hs_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("bp_idle_busy",  32'(busy),        32'd0);
      chk("bp_idle_grt",   32'(bus.rsp_grt), 32'd1);
      @(posedge clk);          // accept edge, one IDLE cycle later
      #1 bus.req_vld = 1'b0;
      chk("bp_accept_busy", 32'(busy), 32'd1);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.rsp_vld) break;
      end
      chk("bp_new_lat", 32'(lat), 32'd4);
      chk("bp_new_grt", 32'(bus.rsp_grt), 32'd0);
      chk("bp_new_lst", 32'(bus.rsp_lst), 32'd1);
      @(negedge clk);
      @(negedge clk);

      // Reset in the middle of CMP
      bus.req_val = 32'h12345678;
      bus.req_rfr = 32'h12345678;
      bus.req_vld = 1'b1;
      @(posedge clk);          // E0
      #1 bus.req_vld = 1'b0;
      @(posedge clk);          // E1
      @(posedge clk);          // E2
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("mid_rst_grt",     32'(bus.rsp_grt), 32'd0);
      chk("mid_rst_lst",     32'(bus.rsp_lst), 32'd0);
      chk("mid_rst_busy",    32'(busy),        32'd0);
      chk("mid_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(32'd5, 32'd3, lat, g, l);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_grt", 32'(g),   32'd1);
      chk("post_rst_lst", 32'(l),   32'd0);
      @(negedge clk);
      @(negedge clk);

      // Back-to-back: req_vld held high over three equal-operand requests
      bus.req_val = 32'hA5A5A5A5;
      bus.req_rfr = 32'hA5A5A5A5;
      bus.req_vld = 1'b1;
      acc = 0; rsp = 0; last = -1; cyc = 0;
      while (cyc < 60 && !(acc == 3 && rsp == 3)) begin
         if (bus.req_vld && bus.req_rdy) begin
            if (acc > 0) chk("b2b_gap", 32'(cyc - last), 32'd6);
            last = cyc;
            acc++;
         end
         if (bus.rsp_vld && bus.rsp_rdy) begin
            rsp++;
            chk("b2b_grt", 32'(bus.rsp_grt), 32'd0);
            chk("b2b_lst", 32'(bus.rsp_lst), 32'd0);
         end
         @(negedge clk);
         cyc++;
         if (acc == 3) bus.req_vld = 1'b0;
      end
      chk("b2b_accepts",   32'(acc), 32'd3);
      chk("b2b_responses", 32'(rsp), 32'd3);
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.rsp_vld) extra++;
         @(negedge clk);
      end
      chk("b2b_extra_rsp", 32'(extra), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
